// File: rtl/axi_write_block.sv
// AXI4-Lite write initiator: pops 32-bit words from a staging FIFO and writes them
// to consecutive word addresses, one transaction outstanding at a time.
module axi_write_block (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [15:0] transfer_size,
    input  logic [31:0] data_in,
    output logic        rd_en,
    input  logic        empty,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SIZE_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FETCH,
        S_LOAD,
        S_ADDR,
        S_RESP,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [SIZE_W-1:0]   size_q, size_nxt;
    logic [SIZE_W-1:0]   count_q, count_nxt;
    logic [SIZE_W:0]     count_sum;
    logic [ADDR_W-1:0]   awaddr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic                rd_en_nxt, awvalid_nxt, wvalid_nxt, bready_nxt;
    logic                busy_nxt, done_nxt, error_nxt;
    logic                aw_done, w_done;

    assign wstrb = 4'hF;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            count_q <= '0;
            awaddr  <= '0;
            wdata   <= '0;
            rd_en   <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            size_q  <= size_nxt;
            count_q <= count_nxt;
            awaddr  <= awaddr_nxt;
            wdata   <= wdata_nxt;
            rd_en   <= rd_en_nxt;
            awvalid <= awvalid_nxt;
            wvalid  <= wvalid_nxt;
            bready  <= bready_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            error   <= error_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        size_nxt    = size_q;
        count_nxt   = count_q;
        awaddr_nxt  = awaddr;
        wdata_nxt   = wdata;
        rd_en_nxt   = 1'b0;
        awvalid_nxt = awvalid;
        wvalid_nxt  = wvalid;
        bready_nxt  = bready;
        error_nxt   = error;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        aw_done     = !awvalid || awready;
        w_done      = !wvalid || wready;
        // 17-bit sum so sizes near 0xFFFF terminate instead of wrapping
        count_sum   = {1'b0, count_q} + 17'd4;

        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_nxt  = addr & ~32'h3;
                    size_nxt  = transfer_size;
                    count_nxt = '0;
                    error_nxt = 1'b0;
                    state_nxt = (transfer_size == 16'd0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (!empty) begin
                    rd_en_nxt = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD: begin
                wdata_nxt   = data_in;
                awaddr_nxt  = addr_q;
                awvalid_nxt = 1'b1;
                wvalid_nxt  = 1'b1;
                state_nxt   = S_ADDR;
            end
            S_ADDR: begin
                if (awready) awvalid_nxt = 1'b0;
                if (wready)  wvalid_nxt  = 1'b0;
                if (aw_done && w_done) begin
                    bready_nxt = 1'b1;
                    state_nxt  = S_RESP;
                end
            end
            S_RESP: begin
                if (bvalid) begin
                    bready_nxt = 1'b0;
                    if (bresp != 2'b00) begin
                        error_nxt = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        count_nxt = count_sum[SIZE_W-1:0];
                        addr_nxt  = addr_q + 32'd4;
                        state_nxt = (count_sum < {1'b0, size_q}) ? S_FILL : S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_axi_write_block.sv
// Directed bench for axi_write_block with a FIFO model and a simple AXI-Lite write slave.
module tb_axi_write_block;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] addr;
    logic [15:0] transfer_size;
    logic [31:0] data_in;
    logic        rd_en;
    logic        empty;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic        busy;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    axi_write_block dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr),
        .transfer_size(transfer_size), .data_in(data_in), .rd_en(rd_en),
        .empty(empty), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // FIFO model: data_in is valid the cycle after rd_en
    logic [31:0] fifo_mem [0:15];
    logic [3:0]  wr_ptr = 4'd0;
    logic [3:0]  rd_ptr;
    logic [3:0]  rd_n;
    assign empty = (wr_ptr == rd_ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= wr_ptr;
            rd_n    <= 4'd0;
            data_in <= 32'd0;
        end else if (rd_en && !empty) begin
            data_in <= fifo_mem[rd_ptr];
            rd_ptr  <= rd_ptr + 4'd1;
            rd_n    <= rd_n + 4'd1;
        end
    end

    // Write slave: response the cycle after both channels are accepted
    logic [31:0] aw_log [0:15];
    logic [31:0] w_log  [0:15];
    logic [3:0]  aw_n, w_n, beat_idx;
    logic [3:0]  bad_beat;
    logic        aw_got, w_got, any_bus;
    logic        aw_hs, w_hs;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_n <= 4'd0; w_n <= 4'd0; beat_idx <= 4'd0;
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            any_bus <= 1'b0;
        end else begin
            if (awvalid || wvalid || rd_en) any_bus <= 1'b1;
            if (aw_hs) begin aw_log[aw_n] <= awaddr; aw_n <= aw_n + 4'd1; end
            if (w_hs)  begin w_log[w_n]   <= wdata;  w_n  <= w_n + 4'd1;  end
            if (!bvalid && (aw_got || aw_hs) && (w_got || w_hs)) begin
                bvalid <= 1'b1;
                bresp  <= (beat_idx == bad_beat) ? 2'b10 : 2'b00;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (bvalid && bready) begin
                bvalid   <= 1'b0;
                beat_idx <= beat_idx + 4'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        fifo_mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_aw(input int max);
        int cyc;
        cyc = 0;
        while (awvalid !== 1'b1 && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        check("awvalid_seen", 32'(awvalid), 32'd1);
    endtask

    task automatic kick(input logic [31:0] a, input logic [15:0] sz);
        addr = a;
        transfer_size = sz;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int stall_bad;
        reset = 1'b1; start = 1'b0; addr = '0; transfer_size = '0;
        awready = 1'b1; wready = 1'b1; bad_beat = 4'hF;
        @(negedge clk);
        do_reset();

        // Reset values
        check("rst_rd_en",   32'(rd_en),   32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid",  32'(wvalid),  32'd0);
        check("rst_bready",  32'(bready),  32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_error",   32'(error),   32'd0);
        check("rst_awaddr",  awaddr,       32'd0);
        check("rst_wdata",   wdata,        32'd0);
        check("rst_wstrb",   32'(wstrb),   32'hF);

        // Three beats, unaligned start address, zero-wait bus
        push(32'hA0A0_0000); push(32'hA1A1_1111); push(32'hA2A2_2222);
        kick(32'h1000_0002, 16'd12);
        check("t1_busy_fill",  32'(busy),  32'd1);
        check("t1_rd_en_fill", 32'(rd_en), 32'd0);
        @(negedge clk);
        check("t1_rd_en_t2",   32'(rd_en), 32'd1);
        @(negedge clk);
        check("t1_rd_en_t3",   32'(rd_en), 32'd0);
        check("t1_awvalid_t3", 32'(awvalid), 32'd0);
        @(negedge clk);
        check("t1_awvalid_t4", 32'(awvalid), 32'd1);
        check("t1_wvalid_t4",  32'(wvalid),  32'd1);
        check("t1_awaddr0",    awaddr, 32'h1000_0000);
        check("t1_wdata0",     wdata,  32'hA0A0_0000);
        wait_done(40, cyc);
        check("t1_done_cycle", 32'(cyc), 32'd12);
        check("t1_error",      32'(error), 32'd0);
        check("t1_aw_n",       32'(aw_n), 32'd3);
        check("t1_aw1",        aw_log[1], 32'h1000_0004);
        check("t1_aw2",        aw_log[2], 32'h1000_0008);
        check("t1_w1",         w_log[1],  32'hA1A1_1111);
        check("t1_w2",         w_log[2],  32'hA2A2_2222);
        check("t1_rd_n",       32'(rd_n), 32'd3);
        check("t1_fifo_empty", 32'(empty), 32'd1);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_busy_idle",  32'(busy), 32'd0);

        // Partial final word: size 6 -> two beats
        do_reset();
        push(32'hB0B0_0000); push(32'hB1B1_1111);
        kick(32'h0000_0000, 16'd6);
        wait_done(40, cyc);
        check("t2_aw_n",  32'(aw_n), 32'd2);
        check("t2_aw0",   aw_log[0], 32'h0000_0000);
        check("t2_aw1",   aw_log[1], 32'h0000_0004);
        check("t2_w1",    w_log[1],  32'hB1B1_1111);
        check("t2_wstrb", 32'(wstrb), 32'hF);

        // Zero-length transfer: no bus activity
        do_reset();
        push(32'hC0C0_0000);
        kick(32'h0000_0100, 16'd0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t3_done_pulse", 32'(done), 32'd0);
        check("t3_busy_idle",  32'(busy), 32'd0);
        check("t3_no_bus",     32'(any_bus), 32'd0);
        check("t3_fifo_kept",  32'(empty), 32'd0);

        // Independent handshakes and FIFO starvation between beats
        do_reset();
        push(32'hD0D0_0000);
        awready = 1'b1; wready = 1'b0;
        kick(32'h0000_0020, 16'd8);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t4_both_valid", 32'({awvalid, wvalid}), 32'd3);
        @(negedge clk);
        check("t4_aw_dropped",  32'(awvalid), 32'd0);
        check("t4_w_held",      32'(wvalid),  32'd1);
        check("t4_wdata_held",  wdata, 32'hD0D0_0000);
        @(negedge clk); @(negedge clk);
        check("t4_w_held3",     32'(wvalid), 32'd1);
        check("t4_bready_wait", 32'(bready), 32'd0);
        wready = 1'b1;
        @(negedge clk);
        check("t4_bready_up",   32'(bready), 32'd1);
        check("t4_w_dropped",   32'(wvalid), 32'd0);
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(busy === 1'b1 && rd_en === 1'b0)) stall_bad++;
        end
        check("t4_stall_fill", 32'(stall_bad), 32'd0);
        awready = 1'b0; wready = 1'b1;
        push(32'hD1D1_1111);
        wait_aw(20);
        check("t4_awaddr1", awaddr, 32'h0000_0024);
        @(negedge clk);
        check("t4_aw_held",  32'(awvalid), 32'd1);
        check("t4_w_gone",   32'(wvalid),  32'd0);
        @(negedge clk); @(negedge clk);
        check("t4_aw_held3", 32'(awvalid), 32'd1);
        check("t4_bready_wait2", 32'(bready), 32'd0);
        awready = 1'b1;
        @(negedge clk);
        check("t4_bready_up2", 32'(bready), 32'd1);
        wait_done(20, cyc);
        check("t4_error", 32'(error), 32'd0);
        check("t4_aw1",   aw_log[1], 32'h0000_0024);
        check("t4_w1",    w_log[1],  32'hD1D1_1111);

        // Error response on the second beat aborts the transfer
        do_reset();
        bad_beat = 4'd1;
        push(32'hE0E0_0000); push(32'hE1E1_1111); push(32'hE2E2_2222);
        kick(32'h0000_0040, 16'd12);
        wait_done(60, cyc);
        check("t5_error",     32'(error), 32'd1);
        check("t5_aw_n",      32'(aw_n),  32'd2);
        check("t5_aw1",       aw_log[1],  32'h0000_0044);
        check("t5_rd_n",      32'(rd_n),  32'd2);
        check("t5_fifo_left", 32'(empty), 32'd0);
        @(negedge clk);
        check("t5_error_held", 32'(error), 32'd1);
        check("t5_busy_idle",  32'(busy),  32'd0);
        bad_beat = 4'hF;

        // Reset while the address/data handshake is pending
        do_reset();
        push(32'hF0F0_0000);
        awready = 1'b0; wready = 1'b0;
        kick(32'h0000_0080, 16'd4);
        wait_aw(10);
        reset = 1'b1;
        @(negedge clk);
        check("t6_outputs", 32'({rd_en, awvalid, wvalid, bready, busy, done, error}), 32'd0);
        check("t6_awaddr",  awaddr, 32'd0);
        check("t6_wdata",   wdata,  32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t6_idle", 32'({busy, awvalid}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
